// File: rtl/muldiv_unit.sv
// muldiv_unit
// ----------------------------------------------------------------------------
// Iterative multiply/divide unit holding the architectural HI/LO registers of
// the MIPS datapath. Operands come straight from the register-file read ports
// (rs -> a, rt -> b). Results land in HI/LO, which feed MFHI/MFLO.
//
// Ports
//   clk    in  1   single clock, all state on posedge
//   reset  in  1   asynchronous, active-high; clears all state
//   start  in  1   request new operation (accepted only when idle)
//   op     in  2   00 MULT, 01 MULTU, 10 DIV, 11 DIVU (sampled with start)
//   a      in  32  rs: multiplicand / dividend (sampled with start)
//   b      in  32  rt: multiplier / divisor (sampled with start)
//   hi_we  in  1   MTHI write enable (idle only)
//   lo_we  in  1   MTLO write enable (idle only)
//   wd     in  32  MTHI/MTLO write data
//   busy   out 1   operation in flight; start and HI/LO writes are dropped
//   done   out 1   one-cycle pulse in the cycle HI/LO show a new result
//   hi     out 32  HI register
//   lo     out 32  LO register
//
// Handshake: start is a single-cycle request; it is taken on an edge where
// busy is low and ignored otherwise (no queueing). done pulses exactly once
// per accepted operation, in the first cycle the new HI/LO are visible.
//
// Build option
//   MULDIV_FAST_MUL_EN  when defined, MULT/MULTU use a combinational 32x32
//                       multiplier: result written one edge after the start
//                       edge, busy never asserted. DIV/DIVU stay iterative.
//
// Latency (iterative path): start taken at E0, 32 RUN steps at E1..E32,
// FIX cycle writes HI/LO at E33; busy is high for 33 cycles.
// ----------------------------------------------------------------------------
module muldiv_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wd,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t      state, state_n;
  logic [4:0]  cnt, cnt_n;
  // Multiply: {partial product, remaining multiplier bits}.
  // Divide:   {partial remainder, dividend bits / quotient bits}.
  logic [63:0] acc, acc_n;
  // Multiplicand magnitude (multiply) or divisor magnitude (divide).
  logic [31:0] mcand, mcand_n;
  logic        is_div, is_div_n;
  logic        neg_q, neg_q_n;       // negate product / quotient
  logic        neg_r, neg_r_n;       // negate remainder (sign of dividend)
  logic        div_zero, div_zero_n;
  logic        busy_n, done_n;
  logic [31:0] hi_n, lo_n;
`ifdef MULDIV_FAST_MUL_EN
  logic        fast_pend, fast_pend_n;
`endif

  // --------------------------------------------------------------------------
  // Operand conditioning at start: signed ops work on magnitudes and fix the
  // sign at the end. 32'h8000_0000 maps to itself, which is the correct
  // unsigned magnitude.
  // --------------------------------------------------------------------------
  logic        op_signed;
  logic [31:0] mag_a, mag_b;

  assign op_signed = ~op[0];
  assign mag_a     = (op_signed && a[31]) ? (32'd0 - a) : a;
  assign mag_b     = (op_signed && b[31]) ? (32'd0 - b) : b;

  // --------------------------------------------------------------------------
  // One iteration step.
  // Multiply: add multiplicand into upper half when the current multiplier
  // bit is set, then shift the whole accumulator right (carry enters bit 63).
  // Divide (restoring): shift left, trial-subtract divisor from the upper
  // half; keep the difference and set the quotient bit when non-negative.
  // The shifted remainder needs 33 bits because it can exceed 32 bits before
  // the subtraction.
  // --------------------------------------------------------------------------
  logic [32:0] mul_sum;
  logic [32:0] rem_sh;
  logic [32:0] div_diff;

  assign mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, mcand} : 33'd0);
  assign rem_sh   = acc[63:31];
  assign div_diff = rem_sh - {1'b0, mcand};

  // --------------------------------------------------------------------------
  // Result sign correction (shared by iterative and fast paths).
  // Divide by zero: the restoring loop naturally yields remainder = |a| and
  // quotient = all ones; re-applying the dividend sign to the remainder
  // restores a, and the quotient is forced so the sign fix cannot alter it.
  // --------------------------------------------------------------------------
  logic [63:0] mag_res;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix, rem_fix;
  logic [31:0] res_hi, res_lo;

`ifdef MULDIV_FAST_MUL_EN
  assign mag_res = fast_pend ? ({32'd0, mcand} * {32'd0, acc[31:0]}) : acc;
`else
  assign mag_res = acc;
`endif

  assign prod_fix = neg_q ? (64'd0 - mag_res) : mag_res;
  assign quo_fix  = neg_q ? (32'd0 - mag_res[31:0]) : mag_res[31:0];
  assign rem_fix  = neg_r ? (32'd0 - mag_res[63:32]) : mag_res[63:32];
  assign res_hi   = is_div ? rem_fix : prod_fix[63:32];
  assign res_lo   = is_div ? (div_zero ? 32'hFFFF_FFFF : quo_fix)
                           : prod_fix[31:0];

  // --------------------------------------------------------------------------
  // Next-state / datapath logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    acc_n      = acc;
    mcand_n    = mcand;
    is_div_n   = is_div;
    neg_q_n    = neg_q;
    neg_r_n    = neg_r;
    div_zero_n = div_zero;
    done_n     = 1'b0;
    hi_n       = hi;
    lo_n       = lo;
`ifdef MULDIV_FAST_MUL_EN
    fast_pend_n = 1'b0;
`endif

    case (state)
      S_IDLE: begin
        if (hi_we) hi_n = wd;
        if (lo_we) lo_n = wd;
`ifdef MULDIV_FAST_MUL_EN
        // Fast multiply result lands one edge after its start and takes
        // priority over an MTHI/MTLO on the same edge.
        if (fast_pend) begin
          hi_n   = res_hi;
          lo_n   = res_lo;
          done_n = 1'b1;
        end
`endif
        if (start) begin
          is_div_n   = op[1];
          cnt_n      = 5'd0;
          div_zero_n = (b == 32'd0);
          if (op[1]) begin
            acc_n   = {32'd0, mag_a};
            mcand_n = mag_b;
            neg_q_n = op_signed & (a[31] ^ b[31]);
            neg_r_n = op_signed & a[31];
          end else begin
            acc_n   = {32'd0, mag_b};
            mcand_n = mag_a;
            neg_q_n = op_signed & (a[31] ^ b[31]);
            neg_r_n = 1'b0;
          end
`ifdef MULDIV_FAST_MUL_EN
          if (op[1]) state_n = S_RUN;
          else       fast_pend_n = 1'b1;
`else
          state_n = S_RUN;
`endif
        end
      end

      S_RUN: begin
        if (is_div) begin
          if (!div_diff[32]) acc_n = {div_diff[31:0], acc[30:0], 1'b1};
          else               acc_n = {rem_sh[31:0],   acc[30:0], 1'b0};
        end else begin
          acc_n = {mul_sum, acc[31:1]};
        end
        cnt_n = cnt + 5'd1;
        if (cnt == 5'd31) state_n = S_FIX;
      end

      S_FIX: begin
        hi_n    = res_hi;
        lo_n    = res_lo;
        done_n  = 1'b1;
        state_n = S_IDLE;
      end

      default: state_n = S_IDLE;
    endcase

    busy_n = (state_n != S_IDLE);
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      cnt      <= 5'd0;
      acc      <= 64'd0;
      mcand    <= 32'd0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      hi       <= 32'd0;
      lo       <= 32'd0;
`ifdef MULDIV_FAST_MUL_EN
      fast_pend <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      acc      <= acc_n;
      mcand    <= mcand_n;
      is_div   <= is_div_n;
      neg_q    <= neg_q_n;
      neg_r    <= neg_r_n;
      div_zero <= div_zero_n;
      busy     <= busy_n;
      done     <= done_n;
      hi       <= hi_n;
      lo       <= lo_n;
`ifdef MULDIV_FAST_MUL_EN
      fast_pend <= fast_pend_n;
`endif
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit
// Self-checking bench for muldiv_unit: driver tasks push expected {HI,LO}
// and the expected done cycle into queues; an independent monitor pops and
// compares whenever done pulses. The reference model uses plain SV integer
// arithmetic on the architectural definitions of MULT/MULTU/DIV/DIVU.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        hi_we, lo_we;
  logic [31:0] wd;
  logic        busy, done;
  logic [31:0] hi, lo;

  muldiv_unit dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .hi_we (hi_we),
    .lo_we (lo_we),
    .wd    (wd),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  // ---------------- scoreboard state ----------------
  int          total = 0;
  int          bad   = 0;
  int          done_cnt = 0;
  logic        prev_done = 1'b0;
  bit          mon_en = 1'b0;
  logic [63:0] exp_q[$];
  int          lat_q[$];
  logic [31:0] model_hi = 32'd0;
  logic [31:0] model_lo = 32'd0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [63:0] ref_model(input logic [1:0] o,
                                            input logic [31:0] x,
                                            input logic [31:0] y);
    longint          sx, sy;
    longint unsigned ux, uy;
    int              qs, rs;
    case (o)
      2'd0: begin
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        return 64'(sx * sy);
      end
      2'd1: begin
        ux = {32'd0, x};
        uy = {32'd0, y};
        return 64'(ux * uy);
      end
      default: begin
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        if (o == 2'd2) begin
          if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF)
            return {32'd0, 32'h8000_0000};
          qs = $signed(x) / $signed(y);
          rs = $signed(x) % $signed(y);
          return {32'(rs), 32'(qs)};
        end
        return {x % y, x / y};
      end
    endcase
  endfunction

  function automatic int lat_of(input logic [1:0] o);
`ifdef MULDIV_FAST_MUL_EN
    return o[1] ? 34 : 2;
`else
    return (o == 2'd0) ? 34 : 34;
`endif
  endfunction

  // ---------------- monitor ----------------
  logic [63:0] mon_e;
  int          mon_l;
  always @(negedge clk) begin
    if (mon_en && !reset) begin
      if (done) begin
        done_cnt++;
        check("done_one_cycle", {63'd0, prev_done}, 64'd0);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL spurious_done: got done=1 expected no pending op (cycle %0d)", cyc);
        end else begin
          mon_e = exp_q.pop_front();
          mon_l = lat_q.pop_front();
          check("result_hilo", {hi, lo}, mon_e);
          check("latency", 64'(cyc), 64'(mon_l));
          check("busy_at_done", {63'd0, busy}, 64'd0);
          model_hi = mon_e[63:32];
          model_lo = mon_e[31:0];
        end
      end
      prev_done = done;
    end else begin
      prev_done = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [1:0] o, input logic [31:0] x,
                       input logic [31:0] y);
    int guard = 0;
    while (busy && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (busy) begin
      total++;
      bad++;
      $display("FAIL issue_wait: got busy=1 expected 0 within 100 cycles");
    end
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    exp_q.push_back(ref_model(o, x, y));
    lat_q.push_back(cyc + lat_of(o));
    @(negedge clk);
    start = 1'b0;
    op    = 2'($urandom_range(0, 3));
    a     = $urandom;
    b     = $urandom;
  endtask

  task automatic drain();
    int guard = 0;
    while (exp_q.size() != 0 && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
      lat_q.delete();
    end
    @(negedge clk);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // ---------------- main sequence ----------------
  int dc;
  initial begin
    reset = 1'b1;
    start = 1'b0;
    op    = 2'd0;
    a     = 32'd0;
    b     = 32'd0;
    hi_we = 1'b0;
    lo_we = 1'b0;
    wd    = 32'd0;
    repeat (3) @(negedge clk);
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_done", {63'd0, done}, 64'd0);
    check("reset_hi", {32'd0, hi}, 64'd0);
    check("reset_lo", {32'd0, lo}, 64'd0);
    reset = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);

    // directed ops from the plan, issued back to back (each new start
    // lands in the previous op's done cycle)
    issue(2'd0, 32'hFFFF_FFFD, 32'd7);
    issue(2'd2, 32'hFFFF_FFF9, 32'd2);
    issue(2'd3, 32'd100, 32'd7);
    issue(2'd3, 32'd5, 32'd0);
    issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    issue(2'd2, 32'hFFFF_FFFB, 32'd0);
    issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(2'd0, 32'h8000_0000, 32'h8000_0000);
    drain();

    // start + MTHI during RUN are dropped
    issue(2'd3, 32'd100, 32'd7);
    repeat (5) @(negedge clk);
    start = 1'b1; op = 2'd0; a = 32'd123; b = 32'd456;
    hi_we = 1'b1; wd = 32'hDEAD_BEEF;
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0;
    check("hi_we_ignored_busy", {32'd0, hi}, {32'd0, model_hi});
    check("busy_in_run", {63'd0, busy}, 64'd1);
    drain();

    // MTHI / MTLO in idle
    hi_we = 1'b1; wd = 32'h0000_1234;
    @(negedge clk);
    hi_we = 1'b0;
    check("mthi_idle", {32'd0, hi}, 64'h1234);
    check("mthi_lo_kept", {32'd0, lo}, {32'd0, model_lo});
    model_hi = 32'h0000_1234;
    lo_we = 1'b1; wd = 32'h0000_5678;
    @(negedge clk);
    lo_we = 1'b0;
    check("mtlo_idle", {32'd0, lo}, 64'h5678);
    check("mtlo_hi_kept", {32'd0, hi}, {32'd0, model_hi});

    // MTHI/MTLO and start on the same idle edge: write applies first
    hi_we = 1'b1; lo_we = 1'b1; wd = 32'hCAFE_F00D;
    issue(2'd2, 32'd1000, 32'hFFFF_FFFD);
    hi_we = 1'b0; lo_we = 1'b0;
    check("same_edge_hi_write", {32'd0, hi}, 64'hCAFE_F00D);
    check("same_edge_lo_write", {32'd0, lo}, 64'hCAFE_F00D);
    drain();

    // reset in the middle of RUN abandons the op
    issue(2'd3, 32'd100, 32'd7);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    lat_q.delete();
    @(negedge clk);
    check("midrun_reset_busy", {63'd0, busy}, 64'd0);
    check("midrun_reset_hi", {32'd0, hi}, 64'd0);
    check("midrun_reset_lo", {32'd0, lo}, 64'd0);
    reset = 1'b0;
    model_hi = 32'd0;
    model_lo = 32'd0;
    dc = done_cnt;
    repeat (40) @(negedge clk);
    check("no_done_after_reset", 64'(done_cnt), 64'(dc));

    // MULTU FFFF_FFFF x 2 (fast build also checks busy stays low)
    issue(2'd1, 32'hFFFF_FFFF, 32'd2);
`ifdef MULDIV_FAST_MUL_EN
    for (int i = 0; i < 3; i++) begin
      check("fast_mul_busy_low", {63'd0, busy}, 64'd0);
      @(negedge clk);
    end
`endif
    drain();

    // randomized ops
    for (int i = 0; i < 40; i++) begin
      issue(2'($urandom_range(0, 3)), pick_operand(), pick_operand());
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 5)) @(negedge clk);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
